// File: rtl/seg_pkg.sv
// Shared types, FSM states and the active-low glyph table for the seven-segment capture block.
package seg_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] hex_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   // One synchronized observation of the display bus.
   typedef struct packed {
      seg_t       seg;
      logic [1:0] an;
   } pair_t;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam int   GLYPH_N   = 16;

   // Index is the hex value; entry is the active-low a..g pattern (bit0 = a).
   localparam seg_t GLYPH_TBL [GLYPH_N] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Exactly one digit enable low; none or both low is an illegal observation.
   function automatic logic an_legal(input logic [1:0] an);
      return (an == 2'b10) || (an == 2'b01);
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph lookup: active-low segment pattern to hex value, plus hit/blank flags.
module seg_decode
   import seg_pkg::*;
(
   input  seg_t i_seg,
   output hex_t o_hex,
   output logic o_hit,
   output logic o_blank
);

   always_comb begin
      o_hex = '0;
      o_hit = 1'b0;
      for (int i = 0; i < GLYPH_N; i++) begin
         if (i_seg == GLYPH_TBL[i]) begin
            o_hex = hex_t'(i);
            o_hit = 1'b1;
         end
      end
   end

   assign o_blank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/seg_capture.sv
// Captures two multiplexed seven-segment digits once their {seg,an} pair is stable; latency 2+STABLE_CYCLES.
// Optional saturating err_count output when SEG_CAPTURE_ERRCNT_EN is defined.
module seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  seg_t       seg,
   input  logic [1:0] an,
   output hex_t       digit0,
   output hex_t       digit1,
   output logic       valid0,
   output logic       valid1,
   output logic       upd,
   output logic       err
`ifdef SEG_CAPTURE_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

   seg_t       r_seg_s1, r_seg_s2;
   logic [1:0] r_an_s1, r_an_s2;
   pair_t      r_pair;
   state_t     r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   hex_t       r_digit0, r_digit1, w_digit0_nxt, w_digit1_nxt;
   logic       r_valid0, r_valid1, w_valid0_nxt, w_valid1_nxt;
   logic       r_upd, r_err, w_upd_nxt, w_err_nxt;

   pair_t      w_pair;
   logic       w_legal, w_changed, w_capture, w_sel1;
   hex_t       w_hex;
   logic       w_hit, w_blank;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seg_s1 <= '0;
         r_seg_s2 <= '0;
         r_an_s1  <= '0;
         r_an_s2  <= '0;
      end else begin
         r_seg_s1 <= seg;
         r_seg_s2 <= r_seg_s1;
         r_an_s1  <= an;
         r_an_s2  <= r_an_s1;
      end
   end

   assign w_pair    = '{seg: r_seg_s2, an: r_an_s2};
   assign w_legal   = an_legal(r_an_s2);
   assign w_changed = (w_pair != r_pair);
   assign w_sel1    = (r_an_s2 == 2'b01);

   seg_decode u_decode (
      .i_seg   (r_seg_s2),
      .o_hex   (w_hex),
      .o_hit   (w_hit),
      .o_blank (w_blank)
   );

   // A legal change drops through IDLE in the same cycle: the new pair is already sample 1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      if (!w_legal) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else if (w_changed) begin
         w_state_nxt = SETTLE;
         w_cnt_nxt   = 8'd1;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = SETTLE;
               w_cnt_nxt   = 8'd1;
            end
            SETTLE: begin
               w_cnt_nxt = r_cnt + 8'd1;
               if (w_cnt_nxt == STABLE_W) begin
                  w_state_nxt = HELD;
                  w_capture   = 1'b1;
               end
            end
            HELD: begin
               w_state_nxt = HELD;
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_digit0_nxt = r_digit0;
      w_digit1_nxt = r_digit1;
      w_valid0_nxt = r_valid0;
      w_valid1_nxt = r_valid1;
      w_err_nxt    = 1'b0;
      if (w_capture) begin
         if (w_sel1) begin
            w_valid1_nxt = w_hit;
            if (w_hit) w_digit1_nxt = w_hex;
         end else begin
            w_valid0_nxt = w_hit;
            if (w_hit) w_digit0_nxt = w_hex;
         end
         w_err_nxt = !w_hit && !w_blank;
      end
      w_upd_nxt = (w_digit0_nxt != r_digit0) || (w_digit1_nxt != r_digit1) ||
                  (w_valid0_nxt != r_valid0) || (w_valid1_nxt != r_valid1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_pair   <= '0;
         r_digit0 <= '0;
         r_digit1 <= '0;
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;
         r_upd    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_pair   <= w_pair;
         r_digit0 <= w_digit0_nxt;
         r_digit1 <= w_digit1_nxt;
         r_valid0 <= w_valid0_nxt;
         r_valid1 <= w_valid1_nxt;
         r_upd    <= w_upd_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign digit0 = r_digit0;
   assign digit1 = r_digit1;
   assign valid0 = r_valid0;
   assign valid1 = r_valid1;
   assign upd    = r_upd;
   assign err    = r_err;

`ifdef SEG_CAPTURE_ERRCNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_count <= '0;
      end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed vectors, hand-written latency/reset sequences and random holds vs a run-length model.
`timescale 1ns/1ps
module tb_seg_capture;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] seg = 7'h7F;
   logic [1:0] an = 2'b11;
   logic [3:0] digit0, digit1;
   logic       valid0, valid1, upd, err;
`ifdef SEG_CAPTURE_ERRCNT_EN
   logic [7:0] err_count;
`endif

   seg_capture #(.STABLE_CYCLES(S)) dut (
      .clk    (clk),
      .reset  (reset),
      .seg    (seg),
      .an     (an),
      .digit0 (digit0),
      .digit1 (digit1),
      .valid0 (valid0),
      .valid1 (valid1),
      .upd    (upd),
      .err    (err)
`ifdef SEG_CAPTURE_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk = ~clk;

   logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int k = 0;
   int upd_seen = 0;
   int err_seen = 0;
   logic [8:0] hist[$];

   logic [3:0] m_d [2];
   logic       m_v [2];
   logic       m_upd, m_err;
   int         m_ecnt;

   typedef struct {
      logic [6:0] s;
      logic [1:0] a;
      int         n;
      logic [3:0] d0, d1;
      logic       v0, v1;
      int         nupd, nerr;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
   endtask

   // Sample seen by the capture logic at edge j: input two edges earlier, zero right after reset.
   function automatic logic [8:0] samp(input int j);
      if (j >= 3) return hist[j-3];
      return 9'h0;
   endfunction

   // Capture happens on the edge where a legal pair has been seen exactly S times in a row.
   function automatic void model_edge();
      logic [8:0] cur;
      logic [6:0] s;
      logic [1:0] a;
      int r, j, idx, dsel;
      logic [3:0] nd;
      logic       nv;
      cur = samp(k);
      s = cur[8:2];
      a = cur[1:0];
      r = 0;
      j = k;
      idx = -1;
      m_upd = 1'b0;
      m_err = 1'b0;
      if (a != 2'b10 && a != 2'b01) return;
      while (j >= 1 && r <= S && samp(j) == cur) begin
         r++;
         j--;
      end
      if (r != S) return;
      for (int g = 0; g < 16; g++) if (GLYPH[g] == s) idx = g;
      dsel = (a == 2'b01) ? 1 : 0;
      nd = m_d[dsel];
      nv = 1'b0;
      if (idx >= 0) begin
         nd = 4'(idx);
         nv = 1'b1;
      end else if (s != 7'h7F) begin
         m_err = 1'b1;
         if (m_ecnt < 255) m_ecnt++;
      end
      if (nd != m_d[dsel] || nv != m_v[dsel]) m_upd = 1'b1;
      m_d[dsel] = nd;
      m_v[dsel] = nv;
   endfunction

   task automatic cycle(input logic [6:0] s, input logic [1:0] a);
      seg = s;
      an  = a;
      hist.push_back({s, a});
      @(posedge clk);
      k++;
      model_edge();
      @(negedge clk);
      upd_seen += int'(upd);
      err_seen += int'(err);
      check("digit0", digit0, m_d[0]);
      check("digit1", digit1, m_d[1]);
      check("valid0", valid0, m_v[0]);
      check("valid1", valid1, m_v[1]);
      check("upd", upd, m_upd);
      check("err", err, m_err);
`ifdef SEG_CAPTURE_ERRCNT_EN
      check("err_count", err_count, m_ecnt);
`endif
   endtask

   // Entered just after a negedge; asserts reset mid-cycle and releases on a later negedge.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_digit0", digit0, 0);
      check("rst_digit1", digit1, 0);
      check("rst_valid0", valid0, 0);
      check("rst_valid1", valid1, 0);
      check("rst_upd", upd, 0);
      check("rst_err", err, 0);
`ifdef SEG_CAPTURE_ERRCNT_EN
      check("rst_err_count", err_count, 0);
`endif
      hist.delete();
      k = 0;
      m_d[0] = 4'h0; m_d[1] = 4'h0;
      m_v[0] = 1'b0; m_v[1] = 1'b0;
      m_upd = 1'b0; m_err = 1'b0; m_ecnt = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [6:0] rs;
      logic [1:0] ra;
      int pick, n;

      tbl[0]  = '{7'h30, 2'b10,  8, 4'h3, 4'h0, 1'b1, 1'b0, 1, 0};
      tbl[1]  = '{7'h0E, 2'b01,  8, 4'h3, 4'hF, 1'b1, 1'b1, 1, 0};
      tbl[2]  = '{7'h30, 2'b10,  8, 4'h3, 4'hF, 1'b1, 1'b1, 0, 0};
      tbl[3]  = '{7'h0E, 2'b01,  8, 4'h3, 4'hF, 1'b1, 1'b1, 0, 0};
      tbl[4]  = '{7'h24, 2'b10,  3, 4'h3, 4'hF, 1'b1, 1'b1, 0, 0};
      tbl[5]  = '{7'h79, 2'b10,  8, 4'h1, 4'hF, 1'b1, 1'b1, 1, 0};
      tbl[6]  = '{7'h7F, 2'b00, 20, 4'h1, 4'hF, 1'b1, 1'b1, 0, 0};
      tbl[7]  = '{7'h7F, 2'b11, 20, 4'h1, 4'hF, 1'b1, 1'b1, 0, 0};
      tbl[8]  = '{7'h55, 2'b01, 10, 4'h1, 4'hF, 1'b1, 1'b0, 1, 1};
      tbl[9]  = '{7'h7F, 2'b10, 10, 4'h1, 4'hF, 1'b0, 1'b0, 1, 0};
      tbl[10] = '{7'h40, 2'b10, 10, 4'h0, 4'hF, 1'b1, 1'b0, 1, 0};
      tbl[11] = '{7'h55, 2'b10, 10, 4'h0, 4'hF, 1'b0, 1'b0, 1, 1};

      @(negedge clk);
      do_reset();

      // First capture lands exactly 2+S edges after the pattern is applied.
      upd_seen = 0;
      for (int c = 1; c <= 10; c++) begin
         cycle(7'h24, 2'b10);
         if (c == 5) check("lat_valid0_early", valid0, 0);
         if (c == 6) begin
            check("lat_digit0", digit0, 2);
            check("lat_valid0", valid0, 1);
         end
      end
      check("lat_upd_count", upd_seen, 1);

      for (int v = 0; v < 12; v++) begin
         upd_seen = 0;
         err_seen = 0;
         for (int c = 0; c < tbl[v].n; c++) cycle(tbl[v].s, tbl[v].a);
         check($sformatf("vec%0d_digit0", v), digit0, tbl[v].d0);
         check($sformatf("vec%0d_digit1", v), digit1, tbl[v].d1);
         check($sformatf("vec%0d_valid0", v), valid0, tbl[v].v0);
         check($sformatf("vec%0d_valid1", v), valid1, tbl[v].v1);
         check($sformatf("vec%0d_upd_count", v), upd_seen, tbl[v].nupd);
         check($sformatf("vec%0d_err_count", v), err_seen, tbl[v].nerr);
      end
`ifdef SEG_CAPTURE_ERRCNT_EN
      check("errcnt_after_table", err_count, 2);
`endif

      for (int i = 0; i < 300; i++) begin
         pick = $urandom_range(0, 19);
         if (pick < 14)      rs = GLYPH[$urandom_range(0, 15)];
         else if (pick < 16) rs = 7'h7F;
         else                rs = 7'($urandom);
         pick = $urandom_range(0, 9);
         ra = (pick < 4) ? 2'b10 : (pick < 8) ? 2'b01 : (pick == 8) ? 2'b00 : 2'b11;
         n = $urandom_range(1, 9);
         for (int c = 0; c < n; c++) cycle(rs, ra);
      end

      // Reset in the middle of a settling window must discard it.
      for (int c = 0; c < 3; c++) cycle(7'h7F, 2'b11);
      for (int c = 0; c < 4; c++) cycle(7'h24, 2'b10);
      do_reset();
      upd_seen = 0;
      err_seen = 0;
      for (int c = 0; c < 12; c++) cycle(7'h7F, 2'b11);
      check("abort_valid0", valid0, 0);
      check("abort_digit0", digit0, 0);
      check("abort_upd_count", upd_seen, 0);
      check("abort_err_count", err_seen, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
